speicher_steuerung: RTL and testbench

Memory access controller between the processor core and the single-port `RAM` block. It accepts instruction-fetch and load/store requests over two independent request/acknowledge ports and grants data accesses priority. It drives the RAM's write-enable, address and write-data inputs and captures the RAM's one-cycle-latency read data into per-port result registers.

---
 rtl/speicher_steuerung.sv | 147 ++++++++++++++
 tb/tb_speicher_steuerung.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_steuerung.sv
// Memory access controller: arbitrates instruction fetch and load/store requests
// onto a single-port RAM with one-cycle read latency, data port has priority.
module speicher_steuerung #(
    parameter int unsigned  WORDSIZE = 32,
    parameter int unsigned  WORDS    = 256,
    localparam int unsigned AW       = $clog2(WORDS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                BefehlAnfrage,
    input  logic [AW-1:0]       BefehlAdresse,
    output logic [WORDSIZE-1:0] BefehlDaten,
    output logic                BefehlFertig,
    input  logic                DatenAnfrage,
    input  logic                DatenSchreiben,
    input  logic [AW-1:0]       DatenAdresse,
    input  logic [WORDSIZE-1:0] DatenSchreibwert,
    output logic [WORDSIZE-1:0] DatenLesewert,
    output logic                DatenFertig,
    output logic                DatenUngueltig,
    output logic                RamSchreibenAn,
    output logic [AW-1:0]       RamAdresse,
    output logic [WORDSIZE-1:0] RamDatenRein,
    input  logic [WORDSIZE-1:0] RamDatenRaus
);

    // One extra bit so the range check also works when WORDS is a power of two.
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        BEREIT,
        LESEN,
        FERTIG
    } zustand_t;

    zustand_t      zustand;
    zustand_t      zustand_next;
    logic          ist_daten;
    logic          ist_daten_next;
    logic          gueltig;
    logic          gueltig_next;
    logic [AW-1:0] adresse_q;
    logic          grant_c;
    logic          lesen_c;
    logic          daten_gueltig_c;
    logic          befehl_gueltig_c;
    logic          befehl_fertig_next;
    logic          daten_fertig_next;
    logic          ungueltig_next;

    assign daten_gueltig_c  = (CW'(DatenAdresse) < CW'(WORDS));
    assign befehl_gueltig_c = (CW'(BefehlAdresse) < CW'(WORDS));
    assign RamDatenRein     = DatenSchreibwert;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand <= BEREIT;
        end else begin
            zustand <= zustand_next;
        end
    end

    // Arbitration, RAM drive and next-state logic
    always_comb begin
        zustand_next       = zustand;
        ist_daten_next     = ist_daten;
        gueltig_next       = gueltig;
        grant_c            = 1'b0;
        lesen_c            = 1'b0;
        RamSchreibenAn     = 1'b0;
        RamAdresse         = adresse_q;
        befehl_fertig_next = 1'b0;
        daten_fertig_next  = 1'b0;
        ungueltig_next     = 1'b0;

        unique case (zustand)
            BEREIT: begin
                if (!Reset && DatenAnfrage) begin
                    grant_c        = 1'b1;
                    ist_daten_next = 1'b1;
                    gueltig_next   = daten_gueltig_c;
                    RamAdresse     = DatenAdresse;
                    if (DatenSchreiben) begin
                        RamSchreibenAn    = daten_gueltig_c;
                        daten_fertig_next = 1'b1;
                        ungueltig_next    = !daten_gueltig_c;
                        zustand_next      = FERTIG;
                    end else begin
                        zustand_next = LESEN;
                    end
                end else if (!Reset && BefehlAnfrage) begin
                    grant_c        = 1'b1;
                    ist_daten_next = 1'b0;
                    gueltig_next   = befehl_gueltig_c;
                    RamAdresse     = BefehlAdresse;
                    zustand_next   = LESEN;
                end
            end
            LESEN: begin
                lesen_c            = 1'b1;
                befehl_fertig_next = !ist_daten;
                daten_fertig_next  = ist_daten;
                ungueltig_next     = ist_daten && !gueltig;
                zustand_next       = FERTIG;
            end
            FERTIG: begin
                zustand_next = BEREIT;
            end
            default: begin
                zustand_next = BEREIT;
            end
        endcase
    end

    // Owner, address hold, completion pulses and result registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ist_daten      <= 1'b0;
            gueltig        <= 1'b0;
            adresse_q      <= '0;
            BefehlFertig   <= 1'b0;
            DatenFertig    <= 1'b0;
            DatenUngueltig <= 1'b0;
            BefehlDaten    <= '0;
            DatenLesewert  <= '0;
        end else begin
            ist_daten      <= ist_daten_next;
            gueltig        <= gueltig_next;
            BefehlFertig   <= befehl_fertig_next;
            DatenFertig    <= daten_fertig_next;
            DatenUngueltig <= ungueltig_next;
            if (grant_c) begin
                adresse_q <= RamAdresse;
            end
            // Out-of-range reads return zero instead of the aliased RAM word.
            if (lesen_c) begin
                if (ist_daten) begin
                    DatenLesewert <= gueltig ? RamDatenRaus : '0;
                end else begin
                    BefehlDaten <= gueltig ? RamDatenRaus : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_speicher_steuerung.sv
// Bench for speicher_steuerung: RAM model, per-cycle reference model, directed
// scenarios with literal expectations, then randomized requests and resets.
module tb_speicher_steuerung;

    localparam int unsigned WS    = 32;
    localparam int unsigned WORDS = 200;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          BefehlAnfrage;
    logic [AW-1:0] BefehlAdresse;
    logic [WS-1:0] BefehlDaten;
    logic          BefehlFertig;
    logic          DatenAnfrage;
    logic          DatenSchreiben;
    logic [AW-1:0] DatenAdresse;
    logic [WS-1:0] DatenSchreibwert;
    logic [WS-1:0] DatenLesewert;
    logic          DatenFertig;
    logic          DatenUngueltig;
    logic          RamSchreibenAn;
    logic [AW-1:0] RamAdresse;
    logic [WS-1:0] RamDatenRein;
    logic [WS-1:0] RamDatenRaus;

    int n_checks = 0;
    int n_fail   = 0;

    speicher_steuerung #(.WORDSIZE(WS), .WORDS(WORDS)) dut (
        .Clock           (clk),
        .Reset           (rst),
        .BefehlAnfrage   (BefehlAnfrage),
        .BefehlAdresse   (BefehlAdresse),
        .BefehlDaten     (BefehlDaten),
        .BefehlFertig    (BefehlFertig),
        .DatenAnfrage    (DatenAnfrage),
        .DatenSchreiben  (DatenSchreiben),
        .DatenAdresse    (DatenAdresse),
        .DatenSchreibwert(DatenSchreibwert),
        .DatenLesewert   (DatenLesewert),
        .DatenFertig     (DatenFertig),
        .DatenUngueltig  (DatenUngueltig),
        .RamSchreibenAn  (RamSchreibenAn),
        .RamAdresse      (RamAdresse),
        .RamDatenRein    (RamDatenRein),
        .RamDatenRaus    (RamDatenRaus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h8020FFFF;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Single-port RAM, one-cycle read latency
    logic [WS-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = init_word(i);
        RamDatenRaus = '0;
        forever begin
            @(posedge clk);
            RamDatenRaus <= ram[RamAdresse];
            if (RamSchreibenAn) ram[RamAdresse] = RamDatenRein;
        end
    end

    // Reference model: each granted access completes at a fixed cycle offset
    logic [WS-1:0] ref_mem [DEPTH];
    int            t;
    int            m_done;
    bit            m_busy, m_owner, m_inval, m_read, ok;
    logic [WS-1:0] m_val, m_bdat, m_dlese;
    logic [AW-1:0] m_last, e_adr;
    logic          e_we, e_bf, e_df, e_du;
    bit            bf_seen, df_seen;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        t = 0; m_done = 0; m_busy = 0; m_owner = 0; m_inval = 0; m_read = 0; ok = 0;
        m_val = '0; m_bdat = '0; m_dlese = '0; m_last = '0;
        bf_seen = 0; df_seen = 0;
        forever begin
            @(negedge clk);
            t++;
            e_we = 1'b0; e_adr = m_last; e_bf = 1'b0; e_df = 1'b0; e_du = 1'b0;
            if (rst) begin
                m_busy = 0; m_bdat = '0; m_dlese = '0; m_last = '0; e_adr = '0;
            end else if (!m_busy) begin
                if (DatenAnfrage) begin
                    ok = int'(DatenAdresse) < int'(WORDS);
                    e_adr = DatenAdresse; m_last = DatenAdresse;
                    m_busy = 1; m_owner = 1; m_inval = !ok;
                    if (DatenSchreiben) begin
                        e_we = ok; m_read = 0; m_done = t + 1;
                        if (ok) begin
                            chk("ram_din", RamDatenRein, DatenSchreibwert);
                            ref_mem[DatenAdresse] = DatenSchreibwert;
                        end
                    end else begin
                        m_read = 1; m_done = t + 2;
                        m_val = ok ? ref_mem[DatenAdresse] : '0;
                    end
                end else if (BefehlAnfrage) begin
                    ok = int'(BefehlAdresse) < int'(WORDS);
                    e_adr = BefehlAdresse; m_last = BefehlAdresse;
                    m_busy = 1; m_owner = 0; m_inval = 0; m_read = 1; m_done = t + 2;
                    m_val = ok ? ref_mem[BefehlAdresse] : '0;
                end
            end else if (t == m_done) begin
                e_bf = !m_owner; e_df = m_owner; e_du = m_owner && m_inval;
                if (m_read) begin
                    if (m_owner) m_dlese = m_val;
                    else m_bdat = m_val;
                end
                m_busy = 0;
            end
            chk1("ram_we", RamSchreibenAn, e_we);
            chk("ram_adr", 32'(RamAdresse), 32'(e_adr));
            chk1("befehl_fertig", BefehlFertig, e_bf);
            chk1("daten_fertig", DatenFertig, e_df);
            chk1("daten_ungueltig", DatenUngueltig, e_du);
            chk("befehl_daten", BefehlDaten, m_bdat);
            chk("daten_lesewert", DatenLesewert, m_dlese);
            bf_seen = BefehlFertig;
            df_seen = DatenFertig;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic new_daten();
        DatenAnfrage     = 1'b1;
        DatenSchreiben   = 1'($urandom_range(0, 1));
        DatenAdresse     = 8'($urandom_range(0, 255));
        DatenSchreibwert = $urandom;
    endtask

    task automatic new_befehl();
        BefehlAnfrage = 1'b1;
        BefehlAdresse = 8'($urandom_range(0, 255));
    endtask

    int rst_left;

    initial begin
        rst = 1'b1;
        BefehlAnfrage = 1'b0; BefehlAdresse = '0;
        DatenAnfrage = 1'b0; DatenSchreiben = 1'b0; DatenAdresse = '0; DatenSchreibwert = '0;
        rst_left = 0;
        smp();
        chk1("reset_bf", BefehlFertig, 1'b0);
        chk("reset_adr", 32'(RamAdresse), 32'h0);
        repeat (2) nxt();
        rst = 1'b0;

        // Fetch from 0
        BefehlAnfrage = 1'b1; BefehlAdresse = 8'd0;
        smp(); chk1("t1_bf_n0", BefehlFertig, 1'b0);
        smp(); chk1("t1_bf_n1", BefehlFertig, 1'b0);
        smp(); chk1("t1_bf", BefehlFertig, 1'b1);
        chk("t1_bdat", BefehlDaten, 32'h8020FFFF);
        chk("t1_dlese", DatenLesewert, 32'h0);
        nxt(); BefehlAnfrage = 1'b0;

        // Store FFFFFFFF to 5, then load it back
        nxt(); DatenAnfrage = 1'b1; DatenSchreiben = 1'b1; DatenAdresse = 8'd5; DatenSchreibwert = 32'hFFFFFFFF;
        smp(); chk1("t2_we", RamSchreibenAn, 1'b1); chk("t2_adr", 32'(RamAdresse), 32'd5);
        smp(); chk1("t2_df", DatenFertig, 1'b1); chk1("t2_we_off", RamSchreibenAn, 1'b0);
        nxt(); DatenSchreiben = 1'b0;
        smp(); smp(); smp();
        chk1("t2_ld_df", DatenFertig, 1'b1); chk("t2_ld", DatenLesewert, 32'hFFFFFFFF);
        nxt(); DatenAnfrage = 1'b0;

        // Simultaneous load from 1 and fetch at 2
        nxt(); DatenAnfrage = 1'b1; DatenSchreiben = 1'b0; DatenAdresse = 8'd1;
        BefehlAnfrage = 1'b1; BefehlAdresse = 8'd2;
        smp(); smp(); smp();
        chk1("t3_df", DatenFertig, 1'b1); chk1("t3_bf_n", BefehlFertig, 1'b0);
        chk("t3_dlese", DatenLesewert, init_word(1));
        nxt(); DatenAnfrage = 1'b0;
        smp(); smp(); smp();
        chk1("t3_bf", BefehlFertig, 1'b1); chk("t3_bdat", BefehlDaten, init_word(2));
        nxt(); BefehlAnfrage = 1'b0;

        // Back-to-back fetches 0,1,2 with the request held
        nxt(); BefehlAnfrage = 1'b1;
        for (int k = 0; k < 3; k++) begin
            BefehlAdresse = 8'(k);
            smp(); chk1("t4_bf_a", BefehlFertig, 1'b0);
            smp(); chk1("t4_bf_b", BefehlFertig, 1'b0);
            smp(); chk1("t4_bf", BefehlFertig, 1'b1);
            chk("t4_bdat", BefehlDaten, init_word(k));
            nxt();
        end
        BefehlAnfrage = 1'b0;
        smp(); chk1("t4_bf_end", BefehlFertig, 1'b0);

        // Reset while a load is in its read cycle
        nxt(); DatenAnfrage = 1'b1; DatenSchreiben = 1'b0; DatenAdresse = 8'd3;
        nxt(); rst = 1'b1;
        smp(); chk1("t5_df_rst", DatenFertig, 1'b0); chk("t5_dlese_rst", DatenLesewert, 32'h0);
        chk("t5_bdat_rst", BefehlDaten, 32'h0); chk("t5_adr_rst", 32'(RamAdresse), 32'h0);
        nxt(); rst = 1'b0;
        smp(); chk1("t5_df_a", DatenFertig, 1'b0);
        smp(); chk1("t5_df_b", DatenFertig, 1'b0);
        smp(); chk1("t5_df", DatenFertig, 1'b1); chk("t5_dlese", DatenLesewert, init_word(3));
        nxt(); DatenAnfrage = 1'b0;

        // Out-of-range store and load at 210
        nxt(); DatenAnfrage = 1'b1; DatenSchreiben = 1'b1; DatenAdresse = 8'd210; DatenSchreibwert = 32'h12345678;
        smp(); chk1("t6_we", RamSchreibenAn, 1'b0);
        smp(); chk1("t6_df", DatenFertig, 1'b1); chk1("t6_du", DatenUngueltig, 1'b1);
        nxt(); DatenSchreiben = 1'b0;
        smp(); smp(); smp();
        chk1("t6_ld_df", DatenFertig, 1'b1); chk1("t6_ld_du", DatenUngueltig, 1'b1);
        chk("t6_ld", DatenLesewert, 32'h0);
        nxt(); DatenAnfrage = 1'b0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            nxt();
            if (rst) begin
                if (rst_left == 0) rst = 1'b0;
                else rst_left--;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                rst_left = int'($urandom_range(0, 1));
            end
            if (DatenAnfrage && df_seen) begin
                if ($urandom_range(0, 1) == 1) new_daten();
                else DatenAnfrage = 1'b0;
            end else if (!DatenAnfrage && $urandom_range(0, 3) == 0) begin
                new_daten();
            end
            if (BefehlAnfrage && bf_seen) begin
                if ($urandom_range(0, 1) == 1) new_befehl();
                else BefehlAnfrage = 1'b0;
            end else if (!BefehlAnfrage && $urandom_range(0, 2) == 0) begin
                new_befehl();
            end
        end
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
